// File: rtl/product_acc_pkg.sv
// Shared types and default sizing for the product accumulator and its
// saturating adder.
package product_acc_pkg;

  localparam int ACC_W_DEF   = 16;
  localparam int CNT_W_DEF   = 8;
  localparam int MUL_LAT_DEF = 2;
  localparam int PROD_W      = 8;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/product_accumulator_sat_add.sv
// Combinational signed saturating adder: ACC_W-bit accumulator plus a
// PROD_W-bit signed addend, clamped to the accumulator range.
module sat_add
  import product_acc_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0]  i_acc,
  input  logic [PROD_W-1:0] i_addend,
  output logic [ACC_W-1:0]  o_sum,
  output logic              o_sat
);

  logic [ACC_W:0] w_wide;

  assign w_wide = {i_acc[ACC_W-1], i_acc}
                + {{(ACC_W+1-PROD_W){i_addend[PROD_W-1]}}, i_addend};

  // Overflow shows up as the two top bits of the widened sum disagreeing;
  // the top bit then tells which rail to clamp to.
  always_comb begin
    o_sum = w_wide[ACC_W-1:0];
    o_sat = 1'b0;
    if (w_wide[ACC_W] != w_wide[ACC_W-1]) begin
      o_sat = 1'b1;
      o_sum = {w_wide[ACC_W], {(ACC_W-1){~w_wide[ACC_W]}}};
    end
  end

endmodule

// File: rtl/product_accumulator.sv
// Signed multiply-accumulate wrapper around an external registered 8-bit
// multiplier: issues operands, realigns products, emits one sum per frame.
module product_accumulator
  import product_acc_pkg::*;
#(
  parameter int ACC_W   = ACC_W_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_x,
  input  logic [7:0]        in_y,
  input  logic              in_last,
  output logic [7:0]        mul_x,
  output logic [7:0]        mul_y,
  input  logic [7:0]        mul_product,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic              out_sat,
  output logic [CNT_W-1:0]  out_count
);

  state_t               r_state;
  state_t               w_nextState;
  logic [7:0]           r_mulX;
  logic [7:0]           r_mulY;
  logic [MUL_LAT-1:0]   r_pipeValid;
  logic [MUL_LAT-1:0]   r_pipeLast;
  logic [ACC_W-1:0]     r_acc;
  logic                 r_sat;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_outValid;
  logic [ACC_W-1:0]     r_outAcc;
  logic                 r_outSat;
  logic [CNT_W-1:0]     r_outCount;

  logic                 w_accept;
  logic                 w_tapValid;
  logic                 w_tapLast;
  logic                 w_finish;
  logic [ACC_W-1:0]     w_sum;
  logic                 w_addSat;
  logic                 w_satNext;
  logic [CNT_W-1:0]     w_cntNext;

  sat_add #(.ACC_W(ACC_W)) u_satAdd (
    .i_acc    (r_acc),
    .i_addend (mul_product),
    .o_sum    (w_sum),
    .o_sat    (w_addSat)
  );

  assign w_accept   = in_valid && in_ready;
  assign w_tapValid = r_pipeValid[MUL_LAT-1];
  assign w_tapLast  = r_pipeLast[MUL_LAT-1];
  assign w_satNext  = r_sat | w_addSat;
  assign w_cntNext  = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);

  always_comb begin
    w_nextState = r_state;
    in_ready    = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      RUN: begin
        in_ready = 1'b1;
        if (w_accept && in_last) w_nextState = DRAIN;
      end
      DRAIN: begin
        if (w_tapValid && w_tapLast) begin
          w_finish    = 1'b1;
          w_nextState = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) w_nextState = RUN;
      end
      default: w_nextState = RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= RUN;
      r_mulX      <= '0;
      r_mulY      <= '0;
      r_pipeValid <= '0;
      r_pipeLast  <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_accept) begin
        r_mulX <= in_x;
        r_mulY <= in_y;
      end
      // The tap at MUL_LAT-1 lines up with the multiplier's product register.
      r_pipeValid[0] <= w_accept;
      r_pipeLast[0]  <= w_accept && in_last;
      for (int i = 1; i < MUL_LAT; i++) begin
        r_pipeValid[i] <= r_pipeValid[i-1];
        r_pipeLast[i]  <= r_pipeLast[i-1];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_acc      <= '0;
      r_sat      <= 1'b0;
      r_cnt      <= '0;
      r_outValid <= 1'b0;
      r_outAcc   <= '0;
      r_outSat   <= 1'b0;
      r_outCount <= '0;
    end else begin
      if (w_finish) begin
        r_outAcc   <= w_sum;
        r_outSat   <= w_satNext;
        r_outCount <= w_cntNext;
        r_outValid <= 1'b1;
        r_acc      <= '0;
        r_sat      <= 1'b0;
        r_cnt      <= '0;
      end else if (w_tapValid) begin
        r_acc <= w_sum;
        r_sat <= w_satNext;
        r_cnt <= w_cntNext;
      end
      if (r_state == HOLD && out_ready) r_outValid <= 1'b0;
    end
  end

  assign mul_x     = r_mulX;
  assign mul_y     = r_mulY;
  assign out_valid = r_outValid;
  assign out_acc   = r_outAcc;
  assign out_sat   = r_outSat;
  assign out_count = r_outCount;

endmodule

// File: tb/tb_product_accumulator.sv
// Drives two accumulators (16-bit and 10-bit) with identical operand frames and
// checks each result against a frame-level arithmetic model.
module tb_product_accumulator;

  localparam int MUL_LAT = 2;

  logic       clock = 1'b0;
  logic       resetN;
  logic       inValid;
  logic [7:0] inX;
  logic [7:0] inY;
  logic       inLast;
  logic       outReady;

  logic        inReadyA, outValidA, outSatA;
  logic [7:0]  mulXA, mulYA, mulProdA, outCountA;
  logic [15:0] outAccA;
  logic        inReadyB, outValidB, outSatB;
  logic [7:0]  mulXB, mulYB, mulProdB, outCountB;
  logic [9:0]  outAccB;

  int checks = 0;
  int errors = 0;
  logic [7:0] frameX[$];
  logic [7:0] frameY[$];
  logic [7:0] tx[$];
  logic [7:0] ty[$];

  always #5 clock = ~clock;

  product_accumulator #(.ACC_W(16), .CNT_W(8), .MUL_LAT(MUL_LAT)) dutA (
    .clock(clock), .reset_n(resetN), .in_valid(inValid), .in_ready(inReadyA),
    .in_x(inX), .in_y(inY), .in_last(inLast), .mul_x(mulXA), .mul_y(mulYA),
    .mul_product(mulProdA), .out_valid(outValidA), .out_ready(outReady),
    .out_acc(outAccA), .out_sat(outSatA), .out_count(outCountA)
  );

  product_accumulator #(.ACC_W(10), .CNT_W(8), .MUL_LAT(MUL_LAT)) dutB (
    .clock(clock), .reset_n(resetN), .in_valid(inValid), .in_ready(inReadyB),
    .in_x(inX), .in_y(inY), .in_last(inLast), .mul_x(mulXB), .mul_y(mulYB),
    .mul_product(mulProdB), .out_valid(outValidB), .out_ready(outReady),
    .out_acc(outAccB), .out_sat(outSatB), .out_count(outCountB)
  );

  // External registered multipliers: low 8 bits of the product.
  initial begin
    mulProdA = '0;
    mulProdB = '0;
  end
  always @(posedge clock) begin
    mulProdA <= mulXA * mulYA;
    mulProdB <= mulXB * mulYB;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Frame-level reference: sequential clamped sum of 8-bit-truncated products.
  task automatic modelFrame(input int accW, output int acc, output int sat, output int cnt);
    int lo, hi, p;
    lo = -(1 << (accW - 1));
    hi = (1 << (accW - 1)) - 1;
    acc = 0;
    sat = 0;
    foreach (frameX[i]) begin
      p = (int'($signed(frameX[i])) * int'($signed(frameY[i]))) & 255;
      if (p > 127) p -= 256;
      acc += p;
      if (acc > hi) begin acc = hi; sat = 1; end
      else if (acc < lo) begin acc = lo; sat = 1; end
    end
    cnt = (frameX.size() > 255) ? 255 : frameX.size();
  endtask

  task automatic checkResults(input string tag);
    int acc, sat, cnt;
    modelFrame(16, acc, sat, cnt);
    checkOutput({tag, ".accA"}, int'($signed(outAccA)), acc);
    checkOutput({tag, ".satA"}, int'(outSatA), sat);
    checkOutput({tag, ".cntA"}, int'(outCountA), cnt);
    modelFrame(10, acc, sat, cnt);
    checkOutput({tag, ".accB"}, int'($signed(outAccB)), acc);
    checkOutput({tag, ".satB"}, int'(outSatB), sat);
    checkOutput({tag, ".cntB"}, int'(outCountB), cnt);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic applyStimulus(input logic [7:0] x, input logic [7:0] y,
                               input logic last, output int waited);
    waited = 0;
    inValid = 1'b1;
    inX = x;
    inY = y;
    inLast = last;
    while (inReadyA !== 1'b1 && waited < 40) begin
      @(negedge clock);
      waited++;
    end
    if (waited >= 40) begin
      errors++;
      $error("[TB] FAIL acceptTimeout observed=%0d expected=<40", waited);
    end
    @(posedge clock);
    frameX.push_back(x);
    frameY.push_back(y);
    @(negedge clock);
    inValid = 1'b0;
    inLast = 1'b0;
    checkOutput("mulX", int'(mulXA), int'(x));
    checkOutput("mulY", int'(mulYB), int'(y));
  endtask

  task automatic runFrame(input string tag, input int stall);
    int waited, lat;
    int snapAcc;
    outReady = (stall == 0);
    foreach (tx[i]) begin
      applyStimulus(tx[i], ty[i], i == tx.size() - 1, waited);
      if (i > 0) checkOutput({tag, ".backToBack"}, waited, 0);
    end
    lat = 0;
    while (outValidA !== 1'b1 && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    checkOutput({tag, ".latency"}, lat, MUL_LAT);
    checkOutput({tag, ".validB"}, int'(outValidB), 1);
    checkOutput({tag, ".readyInHold"}, int'(inReadyA), 0);
    checkResults(tag);
    if (stall > 0) begin
      snapAcc = int'($signed(outAccA));
      repeat (stall) begin
        @(negedge clock);
        checkOutput({tag, ".stallValid"}, int'(outValidA), 1);
        checkOutput({tag, ".stallReady"}, int'(inReadyA), 0);
        checkOutput({tag, ".stallAcc"}, int'($signed(outAccA)), snapAcc);
      end
      checkResults({tag, ".afterStall"});
      outReady = 1'b1;
    end
    @(negedge clock);
    checkOutput({tag, ".validCleared"}, int'(outValidA), 0);
    checkOutput({tag, ".readyBack"}, int'(inReadyA), 1);
    frameX.delete();
    frameY.delete();
    tx.delete();
    ty.delete();
  endtask

  initial begin
    int waited, n;
    resetN = 1'b0;
    inValid = 1'b0;
    inX = '0;
    inY = '0;
    inLast = 1'b0;
    outReady = 1'b1;
    repeat (2) @(negedge clock);
    checkOutput("rst.valid", int'(outValidA), 0);
    checkOutput("rst.acc", int'(outAccA), 0);
    checkOutput("rst.count", int'(outCountB), 0);
    checkOutput("rst.mulX", int'(mulXA), 0);
    resetN = 1'b1;
    @(negedge clock);
    checkOutput("rst.ready", int'(inReadyA), 1);

    tx = '{8'h06}; ty = '{8'h06};
    runFrame("single", 0);

    tx = '{8'h06, 8'hFE, 8'h05}; ty = '{8'h06, 8'h06, 8'hFF};
    runFrame("three", 0);

    tx = '{8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F}; ty = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
    runFrame("posSat", 0);
    tx = '{8'h01}; ty = '{8'h02};
    runFrame("afterSat", 0);

    tx = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80}; ty = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
    runFrame("negSat", 0);

    tx = '{8'h09, 8'hF7}; ty = '{8'h03, 8'h02};
    runFrame("backpressure", 5);

    // Reset in the middle of a frame with products still in flight.
    applyStimulus(8'h11, 8'h03, 1'b0, waited);
    applyStimulus(8'h22, 8'h04, 1'b0, waited);
    resetN = 1'b0;
    #1;
    checkOutput("midRst.mulX", int'(mulXA), 0);
    checkOutput("midRst.mulY", int'(mulYA), 0);
    checkOutput("midRst.valid", int'(outValidA), 0);
    checkOutput("midRst.count", int'(outCountA), 0);
    @(negedge clock);
    resetN = 1'b1;
    frameX.delete();
    frameY.delete();
    repeat (4) begin
      @(negedge clock);
      checkOutput("midRst.noResult", int'(outValidA), 0);
    end
    tx = '{8'h03}; ty = '{8'h04};
    runFrame("postRst", 0);

    for (int f = 0; f < 10; f++) begin
      n = $urandom_range(1, 7);
      for (int k = 0; k < n; k++) begin
        tx.push_back(8'($urandom));
        ty.push_back(8'($urandom));
      end
      runFrame("random", (f % 3 == 0) ? int'($urandom_range(1, 4)) : 0);
    end

    // Long frame: 16-bit sum saturates and the term counter pins at 255.
    for (int k = 0; k < 300; k++) begin
      tx.push_back(8'h7F);
      ty.push_back(8'h01);
    end
    runFrame("long", 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
